// File: rtl/distribuidor_fifos.sv
// distribuidor_fifos: pops words from the principal FIFO and steers each one
// into the class FIFO selected by its two top bits. A single holding stage
// gives in-order delivery, and it honours per-class almost-full backpressure
// (head-of-line blocking). One push counter is kept per class.
module distribuidor_fifos #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              FIFOP_EMPTY,
  input  logic [DATA_W-1:0] FIFOP_DATO,
  output logic              POPFIFOP,
  input  logic [3:0]        ALMOST_FULL,
  output logic [3:0]        PUSH,
  output logic [DATA_W-1:0] DATO_SALIDA,
  input  logic              CLEAR_CNT,
  output logic [CNT_W-1:0]  CUENTA0,
  output logic [CNT_W-1:0]  CUENTA1,
  output logic [CNT_W-1:0]  CUENTA2,
  output logic [CNT_W-1:0]  CUENTA3,
  output logic              IDLE
);

  // Holding-stage occupancy doubles as the controller state
  localparam logic [0:0] ST_VACIO = 1'b0;
  localparam logic [0:0] ST_LLENO = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_hold;
  logic [3:0]        r_push;
  logic [DATA_W-1:0] r_dato;
  logic [CNT_W-1:0]  r_cnt [4];

  logic [1:0]        w_id;
  logic              w_fire;
  logic              w_pop;

  // Push when the held word's class has room; refill in the same cycle so a stream has no bubbles
  always_comb begin
    w_id   = r_hold[DATA_W-1:DATA_W-2];
    w_fire = (r_state == ST_LLENO) && !ALMOST_FULL[w_id];
    w_pop  = RESET_L && !FIFOP_EMPTY && ((r_state == ST_VACIO) || w_fire);
  end

  // Holding stage: capture the principal FIFO head on pop, stay full while blocked
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= ST_VACIO;
      r_hold  <= '0;
    end else begin
      if (w_pop) begin
        r_hold <= FIFOP_DATO;
      end
      if (w_pop || ((r_state == ST_LLENO) && !w_fire)) begin
        r_state <= ST_LLENO;
      end else begin
        r_state <= ST_VACIO;
      end
    end
  end

  // Registered one-hot push strobe and the shared output word
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_push <= 4'b0000;
      r_dato <= '0;
    end else begin
      r_push <= w_fire ? (4'b0001 << w_id) : 4'b0000;
      if (w_fire) begin
        r_dato <= r_hold;
      end
    end
  end

  // Per-class push counters; clear wins over increment and wraparound is silent
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (CLEAR_CNT) begin
          r_cnt[i] <= '0;
        end else if (r_push[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign POPFIFOP    = w_pop;
  assign PUSH        = r_push;
  assign DATO_SALIDA = r_dato;
  assign CUENTA0     = r_cnt[0];
  assign CUENTA1     = r_cnt[1];
  assign CUENTA2     = r_cnt[2];
  assign CUENTA3     = r_cnt[3];
  assign IDLE        = (r_state == ST_VACIO) && FIFOP_EMPTY && (r_push == 4'b0000);

endmodule

// File: tb/tb_distribuidor_fifos.sv
// Testbench for distribuidor_fifos. A queue-based reference model holds the
// principal FIFO contents and at most one staged word. Delivered words are
// logged so that order and content can be compared against what went in.
module tb_distribuidor_fifos;

  logic       CLK;
  logic       RESET_L;
  logic       FIFOP_EMPTY;
  logic [5:0] FIFOP_DATO;
  wire        POPFIFOP;
  logic [3:0] ALMOST_FULL;
  wire  [3:0] PUSH;
  wire  [5:0] DATO_SALIDA;
  logic       CLEAR_CNT;
  wire  [7:0] CUENTA0, CUENTA1, CUENTA2, CUENTA3;
  wire        IDLE;
  wire  [7:0] dut_cnt [4];

  assign dut_cnt[0] = CUENTA0;
  assign dut_cnt[1] = CUENTA1;
  assign dut_cnt[2] = CUENTA2;
  assign dut_cnt[3] = CUENTA3;

  distribuidor_fifos #(.DATA_W(6), .CNT_W(8)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .FIFOP_EMPTY(FIFOP_EMPTY), .FIFOP_DATO(FIFOP_DATO),
    .POPFIFOP(POPFIFOP), .ALMOST_FULL(ALMOST_FULL), .PUSH(PUSH), .DATO_SALIDA(DATO_SALIDA),
    .CLEAR_CNT(CLEAR_CNT), .CUENTA0(CUENTA0), .CUENTA1(CUENTA1), .CUENTA2(CUENTA2),
    .CUENTA3(CUENTA3), .IDLE(IDLE)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int errors = 0;
  int checks = 0;

  logic [5:0] srcq[$];
  logic [5:0] stq[$];
  logic [5:0] in_log[$];
  logic [5:0] got_log[$];
  logic [3:0] m_push = 4'b0000;
  logic [5:0] m_dato = 6'd0;
  logic [7:0] m_cnt [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic [3:0] af = 4'b0000;
  logic       clr = 1'b0;
  logic       gate = 1'b0;

  function automatic logic mfire();
    if (stq.size() == 0) return 1'b0;
    return !af[stq[0][5:4]];
  endfunction

  function automatic logic mpop();
    return RESET_L && !(gate || srcq.size() == 0) && (stq.size() == 0 || mfire());
  endfunction

  function automatic logic midle();
    return (stq.size() == 0) && (gate || srcq.size() == 0) && (m_push == 4'b0000);
  endfunction

  task automatic drive();
    FIFOP_EMPTY = gate || (srcq.size() == 0);
    FIFOP_DATO  = (srcq.size() != 0) ? srcq[0] : 6'($urandom);
    ALMOST_FULL = af;
    CLEAR_CNT   = clr;
  endtask

  task automatic model_reset();
    stq.delete();
    m_push = 4'b0000;
    m_dato = 6'd0;
    for (int c = 0; c < 4; c++) m_cnt[c] = 8'd0;
  endtask

  // One clock cycle: apply inputs, advance the model across the edge, sample 2 time units later
  task automatic tick();
    logic f, p;
    drive();
    #1;
    f = mfire();
    p = mpop();
    @(posedge CLK);
    for (int c = 0; c < 4; c++) begin
      if (clr) m_cnt[c] = 8'd0;
      else if (m_push[c]) m_cnt[c] = m_cnt[c] + 8'd1;
    end
    if (f) begin
      m_push = 4'b0001 << stq[0][5:4];
      m_dato = stq[0];
      void'(stq.pop_front());
    end else begin
      m_push = 4'b0000;
    end
    if (p) stq.push_back(srcq.pop_front());
    #1;
    drive();
    #1;
    if (PUSH != 4'b0000) got_log.push_back(DATO_SALIDA);
  endtask

  task automatic applyStimulus(input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        logic [5:0] w;
        if ($urandom_range(0, 3) != 0 && srcq.size() < 8) begin
          w = 6'($urandom);
          srcq.push_back(w);
          in_log.push_back(w);
        end
        af   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
        gate = ($urandom_range(0, 5) == 0);
        clr  = ($urandom_range(0, 49) == 0);
      end
      tick();
      checks++; if (POPFIFOP !== mpop()) begin errors++; $display("[TB] FAIL rand_pop t=%0t got=%b exp=%b", $time, POPFIFOP, mpop()); end
      checks++; if (PUSH !== m_push) begin errors++; $display("[TB] FAIL rand_push t=%0t got=%b exp=%b", $time, PUSH, m_push); end
      if (m_push != 4'b0000) begin
        checks++; if (DATO_SALIDA !== m_dato) begin errors++; $display("[TB] FAIL rand_dato t=%0t got=%h exp=%h", $time, DATO_SALIDA, m_dato); end
      end
      checks++; if (IDLE !== midle()) begin errors++; $display("[TB] FAIL rand_idle t=%0t got=%b exp=%b", $time, IDLE, midle()); end
      for (int c = 0; c < 4; c++) begin
        checks++; if (dut_cnt[c] !== m_cnt[c]) begin errors++; $display("[TB] FAIL rand_cnt%0d t=%0t got=%0d exp=%0d", c, $time, dut_cnt[c], m_cnt[c]); end
      end
    end
  endtask

  task automatic test_reset();
    RESET_L = 1'b1; FIFOP_EMPTY = 1'b0; FIFOP_DATO = 6'h2A; ALMOST_FULL = 4'b0000; CLEAR_CNT = 1'b0;
    #1 RESET_L = 1'b0;
    #1;
    model_reset();
    checks++; if (POPFIFOP !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop got=%b exp=0", POPFIFOP); end
    checks++; if (PUSH !== 4'b0000) begin errors++; $display("[TB] FAIL reset_push got=%b exp=0000", PUSH); end
    checks++; if (DATO_SALIDA !== 6'd0) begin errors++; $display("[TB] FAIL reset_dato got=%h exp=00", DATO_SALIDA); end
    checks++; if (IDLE !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy got=%b exp=0", IDLE); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (dut_cnt[c] !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt%0d got=%0d exp=0", c, dut_cnt[c]); end
    end
    drive();
    #1;
    checks++; if (IDLE !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle_empty got=%b exp=1", IDLE); end
    @(posedge CLK);
    @(posedge CLK);
    #2 RESET_L = 1'b1;
  endtask

  task automatic test_stream();
    logic [3:0] exp_seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [5:0] words [4]   = '{6'b00_0101, 6'b01_1010, 6'b10_0011, 6'b11_1111};
    for (int i = 0; i < 4; i++) srcq.push_back(words[i]);
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (PUSH !== m_push) begin errors++; $display("[TB] FAIL stream_push k=%0d got=%b exp=%b", k, PUSH, m_push); end
      checks++; if (POPFIFOP !== mpop()) begin errors++; $display("[TB] FAIL stream_pop k=%0d got=%b exp=%b", k, POPFIFOP, mpop()); end
      if (k >= 1 && k <= 4) begin
        checks++; if (PUSH !== exp_seq[k-1]) begin errors++; $display("[TB] FAIL stream_seq k=%0d got=%b exp=%b", k, PUSH, exp_seq[k-1]); end
        checks++; if (DATO_SALIDA !== words[k-1]) begin errors++; $display("[TB] FAIL stream_dato k=%0d got=%h exp=%h", k, DATO_SALIDA, words[k-1]); end
      end
    end
    for (int c = 0; c < 4; c++) begin
      checks++; if (dut_cnt[c] !== 8'd1) begin errors++; $display("[TB] FAIL stream_cnt%0d got=%0d exp=1", c, dut_cnt[c]); end
    end
    checks++; if (IDLE !== 1'b1) begin errors++; $display("[TB] FAIL stream_idle got=%b exp=1", IDLE); end
  endtask

  task automatic test_backpressure();
    af = 4'b0010;
    srcq.push_back(6'b01_0001);
    srcq.push_back(6'b00_0010);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (PUSH !== m_push) begin errors++; $display("[TB] FAIL bp_push k=%0d got=%b exp=%b", k, PUSH, m_push); end
      checks++; if (POPFIFOP !== mpop()) begin errors++; $display("[TB] FAIL bp_pop k=%0d got=%b exp=%b", k, POPFIFOP, mpop()); end
    end
    checks++; if (POPFIFOP !== 1'b0) begin errors++; $display("[TB] FAIL bp_blocked_pop got=%b exp=0", POPFIFOP); end
    checks++; if (PUSH !== 4'b0000) begin errors++; $display("[TB] FAIL bp_blocked_push got=%b exp=0000", PUSH); end
    af = 4'b0000;
    tick();
    checks++; if (PUSH !== 4'b0010) begin errors++; $display("[TB] FAIL bp_release1 got=%b exp=0010", PUSH); end
    checks++; if (DATO_SALIDA !== 6'b01_0001) begin errors++; $display("[TB] FAIL bp_dato1 got=%h exp=%h", DATO_SALIDA, 6'b01_0001); end
    tick();
    checks++; if (PUSH !== 4'b0001) begin errors++; $display("[TB] FAIL bp_release2 got=%b exp=0001", PUSH); end
    checks++; if (DATO_SALIDA !== 6'b00_0010) begin errors++; $display("[TB] FAIL bp_dato2 got=%h exp=%h", DATO_SALIDA, 6'b00_0010); end
    applyStimulus(3, 1'b0);
  endtask

  task automatic test_wrap_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 256; i++) srcq.push_back({2'b10, 4'($urandom)});
    applyStimulus(262, 1'b0);
    checks++; if (CUENTA2 !== 8'd0) begin errors++; $display("[TB] FAIL wrap_cnt2 got=%0d exp=0", CUENTA2); end
    for (int i = 0; i < 3; i++) srcq.push_back({2'b10, 4'($urandom)});
    for (int k = 0; k < 8; k++) begin
      clr = m_push[2] && (m_cnt[2] == 8'd2);
      tick();
      checks++; if (CUENTA2 !== m_cnt[2]) begin errors++; $display("[TB] FAIL clear_cnt2_step k=%0d got=%0d exp=%0d", k, CUENTA2, m_cnt[2]); end
    end
    clr = 1'b0;
    checks++; if (CUENTA2 !== 8'd0) begin errors++; $display("[TB] FAIL clear_cnt2 got=%0d exp=0", CUENTA2); end
  endtask

  task automatic test_reset_mid_stall();
    af = 4'b0010;
    srcq.push_back(6'b01_1100);
    srcq.push_back(6'b10_0110);
    applyStimulus(3, 1'b0);
    RESET_L = 1'b0;
    model_reset();
    #1;
    checks++; if (POPFIFOP !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_pop got=%b exp=0", POPFIFOP); end
    checks++; if (PUSH !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_push got=%b exp=0000", PUSH); end
    checks++; if (DATO_SALIDA !== 6'd0) begin errors++; $display("[TB] FAIL rst_mid_dato got=%h exp=00", DATO_SALIDA); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (dut_cnt[c] !== 8'd0) begin errors++; $display("[TB] FAIL rst_mid_cnt%0d got=%0d exp=0", c, dut_cnt[c]); end
    end
    tick();
    RESET_L = 1'b1;
    af = 4'b0000;
    got_log.delete();
    applyStimulus(5, 1'b0);
    checks++; if (got_log.size() !== 1) begin errors++; $display("[TB] FAIL rst_mid_count got=%0d exp=1", got_log.size()); end
    if (got_log.size() != 0) begin
      checks++; if (got_log[0] !== 6'b10_0110) begin errors++; $display("[TB] FAIL rst_mid_word got=%h exp=%h", got_log[0], 6'b10_0110); end
    end
  endtask

  task automatic test_empty_gaps();
    logic prev_push = 1'b0;
    for (int i = 0; i < 6; i++) srcq.push_back(6'($urandom));
    for (int k = 0; k < 16; k++) begin
      gate = (k % 2 == 0);
      tick();
      checks++; if (PUSH !== m_push) begin errors++; $display("[TB] FAIL gap_push k=%0d got=%b exp=%b", k, PUSH, m_push); end
      checks++; if (IDLE !== midle()) begin errors++; $display("[TB] FAIL gap_idle k=%0d got=%b exp=%b", k, IDLE, midle()); end
      checks++; if (prev_push && PUSH != 4'b0000) begin errors++; $display("[TB] FAIL gap_adjacent k=%0d got=%b exp=0000", k, PUSH); end
      prev_push = (PUSH != 4'b0000);
    end
    gate = 1'b1;
    tick();
    tick();
    checks++; if (IDLE !== 1'b1) begin errors++; $display("[TB] FAIL gap_drained_idle got=%b exp=1", IDLE); end
    gate = 1'b0;
  endtask

  task automatic test_random();
    in_log.delete();
    got_log.delete();
    applyStimulus(300, 1'b1);
    af = 4'b0000; gate = 1'b0; clr = 1'b0;
    applyStimulus(20, 1'b0);
    checks++; if (got_log.size() !== in_log.size()) begin errors++; $display("[TB] FAIL rand_count got=%0d exp=%0d", got_log.size(), in_log.size()); end
    for (int i = 0; i < in_log.size() && i < got_log.size(); i++) begin
      checks++; if (got_log[i] !== in_log[i]) begin errors++; $display("[TB] FAIL rand_order i=%0d got=%h exp=%h", i, got_log[i], in_log[i]); end
    end
  endtask

  task automatic checkOutput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap_clear();
    test_reset_mid_stall();
    test_empty_gaps();
    test_random();
    checkOutput();
    $finish;
  end

endmodule
